// File: rtl/latch_8bit_ctrl_if.sv
// Bus-side request/response bundle for latch_8bit_ctrl.
//   wr_req, rd_req, wr_data : requester -> controller (single-cycle requests)
//   busy, done, rd_valid    : controller status (registered)
//   rd_data                 : last byte captured from the latch
// master = core logic issuing requests, slave = the controller.
interface latch_8bit_ctrl_if;
  logic       wr_req;
  logic       rd_req;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (
    output wr_req, rd_req, wr_data,
    input  busy, done, rd_data, rd_valid
  );

  modport slave (
    input  wr_req, rd_req, wr_data,
    output busy, done, rd_data, rd_valid
  );
endinterface

// File: rtl/latch_8bit_ctrl.sv
// Controller for one 8-bit transparent latch (LE active-high, nOE active-low).
// Turns single-cycle write/read requests into timed LE strobes and nOE access
// windows.
//   clk     : system clock, rising edge
//   rst     : synchronous reset, active-high
//   bus     : request/status bundle (slave side)
//   lat_d   : latch data input
//   lat_le  : latch enable
//   lat_noe : latch output enable, active-low
//   lat_q   : latch data output
// Write latency (accept edge to done) = SETUP_CYC+PULSE_CYC+HOLD_CYC+1,
// read latency = ACC_CYC+2. All outputs are registered.
module latch_8bit_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned ACC_CYC   = 2,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  latch_8bit_ctrl_if.slave    bus,
  output logic [7:0]          lat_d,
  output logic                lat_le,
  output logic                lat_noe,
  input  logic [7:0]          lat_q
);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    R_ACCESS,
    R_SAMPLE,
    FINISH
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] ACC_LD   = CNT_W'(ACC_CYC - 1);

  state_t           state,   stateNext;
  logic [CNT_W-1:0] cnt,     cntNext;
  logic [7:0]       latD,    latDNext;
  logic             latLe,   latLeNext;
  logic             latNoe,  latNoeNext;
  logic             busy,    busyNext;
  logic             done,    doneNext;
  logic             rdValid, rdValidNext;
  logic [7:0]       rdData,  rdDataNext;
  logic             rdPend,  rdPendNext;

  // Every output is computed one cycle ahead here and registered below, so
  // strobe edges line up with state transitions and nothing is combinational
  // from inputs to outputs.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    latDNext    = latD;
    latLeNext   = latLe;
    latNoeNext  = latNoe;
    busyNext    = busy;
    doneNext    = 1'b0;
    rdValidNext = 1'b0;
    rdDataNext  = rdData;
    rdPendNext  = rdPend;

    case (state)
      IDLE: begin
        cntNext = '0;
        // Write wins over a simultaneous read; the read is simply dropped.
        if (bus.wr_req) begin
          latDNext  = bus.wr_data;
          cntNext   = SETUP_LD;
          busyNext  = 1'b1;
          stateNext = W_SETUP;
        end else if (bus.rd_req) begin
          latNoeNext = 1'b0;
          cntNext    = ACC_LD;
          busyNext   = 1'b1;
          stateNext  = R_ACCESS;
        end
      end

      W_SETUP: begin
        if (cnt == '0) begin
          latLeNext = 1'b1;
          cntNext   = PULSE_LD;
          stateNext = W_PULSE;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end

      W_PULSE: begin
        if (cnt == '0) begin
          latLeNext = 1'b0;
          cntNext   = HOLD_LD;
          stateNext = W_HOLD;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end

      W_HOLD: begin
        if (cnt == '0) begin
          stateNext = FINISH;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end

      R_ACCESS: begin
        // Capture on the edge that closes the access window, while nOE is
        // still low, and release the latch output at that same edge.
        if (cnt == '0) begin
          rdDataNext = lat_q;
          latNoeNext = 1'b1;
          stateNext  = R_SAMPLE;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end

      R_SAMPLE: begin
        rdPendNext = 1'b1;
        stateNext  = FINISH;
      end

      FINISH: begin
        doneNext    = 1'b1;
        rdValidNext = rdPend;
        rdPendNext  = 1'b0;
        busyNext    = 1'b0;
        cntNext     = '0;
        stateNext   = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      latD    <= '0;
      latLe   <= 1'b0;
      latNoe  <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdValid <= 1'b0;
      rdData  <= '0;
      rdPend  <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      latD    <= latDNext;
      latLe   <= latLeNext;
      latNoe  <= latNoeNext;
      busy    <= busyNext;
      done    <= doneNext;
      rdValid <= rdValidNext;
      rdData  <= rdDataNext;
      rdPend  <= rdPendNext;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.rd_valid = rdValid;
  assign bus.rd_data  = rdData;
  assign lat_d        = latD;
  assign lat_le       = latLe;
  assign lat_noe      = latNoe;

endmodule

// File: tb/tb_latch_8bit_ctrl.sv
// Bench for latch_8bit_ctrl: two instances (default timing and a swept
// timing) share one request stream, each driving its own transparent-latch
// model. Expected outputs come from a transaction-level model that tracks the
// elapsed cycles since acceptance and derives every strobe from the timing
// windows.
module tb_latch_8bit_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wrReq;
  logic       rdReq;
  logic [7:0] wrData;
  bit         latchInit = 1'b1;

  int errCount = 0;
  int chkCount = 0;

  always #5 clk = ~clk;

  latch_8bit_ctrl_if ifA ();
  latch_8bit_ctrl_if ifB ();

  assign ifA.wr_req  = wrReq;
  assign ifA.rd_req  = rdReq;
  assign ifA.wr_data = wrData;
  assign ifB.wr_req  = wrReq;
  assign ifB.rd_req  = rdReq;
  assign ifB.wr_data = wrData;

  logic [7:0] dA, qA, memA, dB, qB, memB;
  logic       leA, noeA, leB, noeB;

  latch_8bit_ctrl dutA (
    .clk     (clk),
    .rst     (rst),
    .bus     (ifA),
    .lat_d   (dA),
    .lat_le  (leA),
    .lat_noe (noeA),
    .lat_q   (qA)
  );

  latch_8bit_ctrl #(
    .SETUP_CYC (3),
    .PULSE_CYC (1),
    .HOLD_CYC  (2),
    .ACC_CYC   (4),
    .CNT_W     (4)
  ) dutB (
    .clk     (clk),
    .rst     (rst),
    .bus     (ifB),
    .lat_d   (dB),
    .lat_le  (leB),
    .lat_noe (noeB),
    .lat_q   (qB)
  );

  // Transparent latches; a released output shows a junk pattern so a capture
  // outside the nOE window is visible.
  always_latch if (leA || latchInit) memA <= latchInit ? 8'h00 : dA;
  always_latch if (leB || latchInit) memB <= latchInit ? 8'h00 : dB;
  assign qA = noeA ? 8'hEE : memA;
  assign qB = noeB ? 8'hEE : memB;

  // Reference model, one entry per instance.
  typedef struct {
    bit         active;
    bit         isWr;
    int         t;
    logic [7:0] latD;
    logic [7:0] mem;
    logic [7:0] lastRd;
  } mdl_t;

  mdl_t        m [2];
  int unsigned sCyc [2] = '{1, 3};
  int unsigned pCyc [2] = '{2, 1};
  int unsigned hCyc [2] = '{1, 2};
  int unsigned aCyc [2] = '{2, 4};

  function automatic int latency(int k);
    return m[k].isWr ? int'(sCyc[k] + pCyc[k] + hCyc[k] + 1) : int'(aCyc[k] + 2);
  endfunction

  function automatic bit expLe(int k);
    return m[k].active && m[k].isWr &&
           m[k].t >= int'(sCyc[k]) && m[k].t < int'(sCyc[k] + pCyc[k]);
  endfunction

  function automatic bit expNoe(int k);
    return !(m[k].active && !m[k].isWr && m[k].t < int'(aCyc[k]));
  endfunction

  function automatic bit expBusy(int k);
    return m[k].active && m[k].t < latency(k);
  endfunction

  function automatic bit expDone(int k);
    return m[k].active && m[k].t == latency(k);
  endfunction

  // Advance the model across one rising edge with the inputs now applied.
  task automatic modelEdge(int k);
    if (rst) begin
      m[k].active = 1'b0;
      m[k].latD   = 8'h00;
      m[k].lastRd = 8'h00;
    end else if (m[k].active && m[k].t < latency(k)) begin
      m[k].t++;
    end else if (wrReq) begin
      m[k].active = 1'b1;
      m[k].isWr   = 1'b1;
      m[k].t      = 0;
      m[k].latD   = wrData;
    end else if (rdReq) begin
      m[k].active = 1'b1;
      m[k].isWr   = 1'b0;
      m[k].t      = 0;
    end else begin
      m[k].active = 1'b0;
    end
    if (expLe(k)) m[k].mem = m[k].latD;
    if (m[k].active && !m[k].isWr && m[k].t == int'(aCyc[k]))
      m[k].lastRd = m[k].mem;
  endtask

  task automatic checkVal(string tag, logic [7:0] got, logic [7:0] exp);
    chkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkInst(string nm, int k, logic busy, logic done, logic rdv,
                           logic [7:0] rdd, logic [7:0] ld, logic le, logic noe);
    checkVal({nm, ".busy"},     {7'd0, busy}, {7'd0, expBusy(k)});
    checkVal({nm, ".done"},     {7'd0, done}, {7'd0, expDone(k)});
    checkVal({nm, ".rd_valid"}, {7'd0, rdv},  {7'd0, expDone(k) && !m[k].isWr});
    checkVal({nm, ".rd_data"},  rdd,          m[k].lastRd);
    checkVal({nm, ".lat_d"},    ld,           m[k].latD);
    checkVal({nm, ".lat_le"},   {7'd0, le},   {7'd0, expLe(k)});
    checkVal({nm, ".lat_noe"},  {7'd0, noe},  {7'd0, expNoe(k)});
  endtask

  // One clock: apply inputs, predict the edge, then check on the falling edge.
  task automatic step(bit r, bit w, bit rd, logic [7:0] d);
    rst    = r;
    wrReq  = w;
    rdReq  = rd;
    wrData = d;
    modelEdge(0);
    modelEdge(1);
    @(negedge clk);
    latchInit = 1'b0;
    checkInst("A", 0, ifA.busy, ifA.done, ifA.rd_valid, ifA.rd_data, dA, leA, noeA);
    checkInst("B", 1, ifB.busy, ifB.done, ifB.rd_valid, ifB.rd_data, dB, leB, noeB);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m[k].active = 1'b0;
      m[k].isWr   = 1'b0;
      m[k].t      = 0;
      m[k].latD   = 8'h00;
      m[k].mem    = 8'h00;
      m[k].lastRd = 8'h00;
    end

    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Write interrupted by a two-cycle reset while LE is high.
    step(1'b0, 1'b1, 1'b0, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    idle(3);

    // Full write of A5.
    step(1'b0, 1'b1, 1'b0, 8'hA5);
    idle(9);

    // Write 3C then read it back.
    step(1'b0, 1'b1, 1'b0, 8'h3C);
    idle(9);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    idle(8);

    // Simultaneous requests: write wins.
    step(1'b0, 1'b1, 1'b1, 8'h81);
    idle(9);

    // Read requests every cycle during a write, then one right after done.
    step(1'b0, 1'b1, 1'b0, 8'h5A);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    idle(8);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 4,
           8'($urandom_range(0, 255)));
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", chkCount, errCount);
    $finish;
  end

endmodule

// File: doc/latch_8bit_ctrl.md
Name: latch_8bit_ctrl

Overview:
Synchronous bus-side controller that drives one 8-bit transparent latch with output enable (LE active-high, nOE active-low, tri-state Q). Converts single-cycle write/read requests into timed LE strobe and nOE access sequences. Sits between core logic and the latch_8bit register; writes load the latch, reads enable its output and capture the value.

Parameters:
SETUP_CYC, 1, cycles lat_d is stable before LE rises (>=1)
PULSE_CYC, 2, cycles LE held high (>=1)
HOLD_CYC, 1, cycles lat_d held after LE falls (>=1)
ACC_CYC, 2, cycles nOE held low before lat_q is sampled (>=1)
CNT_W, 4, width of the internal phase counter; must hold max(param)-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
wr_req  input  1  start write of wr_data; accepted only when busy=0
rd_req  input  1  start read; accepted only when busy=0
wr_data  input  8  byte to write, sampled at acceptance
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse at the end of every transaction
rd_data  output  8  last captured latch value
rd_valid  output  1  one-cycle pulse with done on reads only
lat_d  output  8  drives latch inData
lat_le  output  1  drives latch LE
lat_noe  output  1  drives latch nOE
lat_q  input  8  latch outData

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE, busy=0, done=0, rd_valid=0, rd_data=8'h00, lat_d=8'h00, lat_le=0, lat_noe=1, counter=0. Reset mid-transaction aborts immediately: LE drops and nOE returns high the same edge; no done pulse.
- All outputs registered; no combinational path from inputs to outputs.
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, R_SAMPLE, FINISH.
- IDLE: if wr_req=1 -> latch wr_data into lat_d, go W_SETUP, busy=1. Else if rd_req=1 -> lat_noe=0, go R_ACCESS, busy=1. Simultaneous wr_req and rd_req: write wins; read is dropped (requester re-issues).
- Requests while busy=1 are ignored; no queuing.
- W_SETUP: lat_le=0, lat_d stable; stay SETUP_CYC cycles, then lat_le=1, go W_PULSE.
- W_PULSE: lat_le=1 for exactly PULSE_CYC cycles, then lat_le=0, go W_HOLD.
- W_HOLD: lat_d unchanged for HOLD_CYC cycles, then go FINISH.
- lat_noe stays 1 throughout a write; lat_le stays 0 throughout a read.
- R_ACCESS: lat_noe=0 for ACC_CYC cycles, then go R_SAMPLE.
- R_SAMPLE: rd_data<=lat_q, lat_noe<=1, go FINISH with rd_valid flagged.
- FINISH: done=1 (and rd_valid=1 if read) for one cycle, busy=0 at the same edge, return to IDLE. A new request is accepted on the cycle after done (IDLE).
- Counter: loads param-1 on state entry, decrements, transitions at 0; never wraps.
- Latency: write from accept edge to done = SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles; read = ACC_CYC+2 cycles. Default: write 5, read 4.
- rd_data holds its value until the next read completes or reset; writes do not modify it.
- lat_d retains the last written byte after a write (not cleared in IDLE).

Test Plan:
- Reset: assert rst 2 cycles mid-pulse -> lat_le=0, lat_noe=1, busy=0, rd_data=00, no done pulse.
- Write 8'hA5 with defaults: wr_req one cycle -> lat_d=A5 one cycle before lat_le rises, lat_le high exactly 2 cycles, done pulse 5 cycles after accept, lat_noe stays 1.
- Write then read with model latch: write 8'h3C, read -> lat_noe low 2 cycles, rd_data=3C, rd_valid and done pulse together 4 cycles after accept.
- Simultaneous wr_req+rd_req with wr_data=8'h81 -> write performed, no rd_valid, rd_data unchanged.
- Requests during busy: pulse rd_req every cycle mid-write -> ignored, only one done; read accepted the cycle after done.
- Parameter sweep SETUP=3, PULSE=1, HOLD=2, ACC=4 -> LE high 1 cycle, write latency 7, read latency 6, rd_data matches last written byte.
